// File: rtl/uart_st_fifo.sv
// rtl/uart_st_fifo.sv - Avalon-ST UART with TX/RX FIFOs; UART_HW_FLOWCTRL_EN adds CTS_N/RTS_N flow control
// Frame: start, DATA_BITS LSB first, optional parity, STOP_BITS stop bits; every bit lasts BAUD_DIV clocks.

module uart_st_fifo_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q;
  logic [AW:0]      rd_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop  = pop_i && !empty_o;
  // A pop frees the slot this cycle, so a push into a full FIFO is still taken.
  assign do_push = push_i && (!full_o || do_pop);
  assign head_o  = mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q <= '0;
      rd_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q[AW-1:0]] <= push_data_i;
        wr_q                <= wr_q + 1'b1;
      end
      if (do_pop) rd_q <= rd_q + 1'b1;
    end
  end
endmodule

module uart_st_fifo #(
  parameter int BAUD_DIV  = 434,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1,
  parameter int TX_DEPTH  = 16,
  parameter int RX_DEPTH  = 16
) (
  input  logic                 clk_clk,
  input  logic                 reset_reset,
  input  logic [DATA_BITS-1:0] avalon_data_transmit_sink_data,
  input  logic                 avalon_data_transmit_sink_error,
  input  logic                 avalon_data_transmit_sink_valid,
  output logic                 avalon_data_transmit_sink_ready,
  output logic [DATA_BITS-1:0] avalon_data_receive_source_data,
  output logic [1:0]           avalon_data_receive_source_error,
  output logic                 avalon_data_receive_source_valid,
  input  logic                 avalon_data_receive_source_ready,
  output logic                 rx_overrun,
`ifdef UART_HW_FLOWCTRL_EN
  input  logic                 external_interface_CTS_N,
  output logic                 external_interface_RTS_N,
`endif
  input  logic                 external_interface_RXD,
  output logic                 external_interface_TXD
);
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);
  localparam logic [15:0] HALF_LAST = 16'(BAUD_DIV / 2 - 1);
  localparam logic [3:0]  BITS_LAST = 4'(DATA_BITS - 1);
  localparam logic        STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic        HAS_PAR   = 1'(PARITY != 0);
  localparam logic        PAR_ODD   = 1'(PARITY == 1);

  logic                 tx_full;
  logic                 tx_empty;
  logic [DATA_BITS:0]   tx_head;
  logic                 tx_tick;
  logic                 tx_free;
  logic                 tx_pop;
  logic                 cts_ok;
  state_t               tx_state_q;
  logic [15:0]          tx_baud_q;
  logic [3:0]           tx_bit_q;
  logic                 tx_stop_q;
  logic [DATA_BITS-1:0] tx_shift_q;
  logic                 tx_par_q;
  logic                 txd_q;

  assign avalon_data_transmit_sink_ready = !reset_reset && !tx_full;
  assign external_interface_TXD          = txd_q;

  uart_st_fifo_fifo #(.WIDTH(DATA_BITS + 1), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk_i       (clk_clk),
    .rst_i       (reset_reset),
    .push_i      (avalon_data_transmit_sink_valid && avalon_data_transmit_sink_ready),
    .push_data_i ({avalon_data_transmit_sink_error, avalon_data_transmit_sink_data}),
    .pop_i       (tx_pop),
    .head_o      (tx_head),
    .full_o      (tx_full),
    .empty_o     (tx_empty)
  );

  assign tx_tick = (tx_baud_q == 16'd0);
  // The final stop-bit tick behaves like IDLE so the next frame starts with no gap.
  assign tx_free = (tx_state_q == S_IDLE) ||
                   ((tx_state_q == S_STOP) && tx_tick && (tx_stop_q == STOP_LAST));
  assign tx_pop  = tx_free && !tx_empty && cts_ok;

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      tx_state_q <= S_IDLE;
      tx_baud_q  <= '0;
      tx_bit_q   <= '0;
      tx_stop_q  <= 1'b0;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
      txd_q      <= 1'b1;
    end else if (tx_pop && !tx_head[DATA_BITS]) begin
      tx_state_q <= S_START;
      tx_baud_q  <= BAUD_LAST;
      tx_bit_q   <= '0;
      tx_stop_q  <= 1'b0;
      tx_shift_q <= tx_head[DATA_BITS-1:0];
      tx_par_q   <= (^tx_head[DATA_BITS-1:0]) ^ PAR_ODD;
      txd_q      <= 1'b0;
    end else if (tx_free) begin
      tx_state_q <= S_IDLE;
      txd_q      <= 1'b1;
    end else if (tx_tick) begin
      tx_baud_q <= BAUD_LAST;
      case (tx_state_q)
        S_START: begin
          tx_state_q <= S_DATA;
          txd_q      <= tx_shift_q[0];
        end
        S_DATA: begin
          if (tx_bit_q == BITS_LAST) begin
            tx_state_q <= HAS_PAR ? S_PARITY : S_STOP;
            txd_q      <= HAS_PAR ? tx_par_q : 1'b1;
          end else begin
            tx_bit_q   <= tx_bit_q + 4'd1;
            tx_shift_q <= tx_shift_q >> 1;
            txd_q      <= tx_shift_q[1];
          end
        end
        S_PARITY: begin
          tx_state_q <= S_STOP;
          txd_q      <= 1'b1;
        end
        S_STOP:  tx_stop_q  <= 1'b1;
        default: tx_state_q <= S_IDLE;
      endcase
    end else begin
      tx_baud_q <= tx_baud_q - 16'd1;
    end
  end

  logic                 rx_s1_q;
  logic                 rx_s2_q;
  logic                 rx_prev_q;
  state_t               rx_state_q;
  logic [15:0]          rx_baud_q;
  logic [3:0]           rx_bit_q;
  logic                 rx_stop_q;
  logic [DATA_BITS-1:0] rx_shift_q;
  logic                 rx_perr_q;
  logic                 rx_overrun_q;
  logic                 rx_tick;
  logic                 rx_wr;
  logic                 rx_pop;
  logic                 rx_full;
  logic                 rx_empty;
  logic [DATA_BITS+1:0] rx_head;

  assign rx_tick = (rx_baud_q == 16'd0);
  assign rx_wr   = (rx_state_q == S_STOP) && rx_tick && !rx_stop_q;
  assign rx_pop  = !rx_empty && avalon_data_receive_source_ready;

  uart_st_fifo_fifo #(.WIDTH(DATA_BITS + 2), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk_i       (clk_clk),
    .rst_i       (reset_reset),
    .push_i      (rx_wr),
    .push_data_i ({rx_perr_q, !rx_s2_q, rx_shift_q}),
    .pop_i       (rx_pop),
    .head_o      (rx_head),
    .full_o      (rx_full),
    .empty_o     (rx_empty)
  );

  assign avalon_data_receive_source_valid = !rx_empty;
  assign avalon_data_receive_source_data  = rx_head[DATA_BITS-1:0];
  assign avalon_data_receive_source_error = rx_head[DATA_BITS+1:DATA_BITS];
  assign rx_overrun                       = rx_overrun_q;

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      rx_s1_q      <= 1'b1;
      rx_s2_q      <= 1'b1;
      rx_prev_q    <= 1'b1;
      rx_state_q   <= S_IDLE;
      rx_baud_q    <= '0;
      rx_bit_q     <= '0;
      rx_stop_q    <= 1'b0;
      rx_shift_q   <= '0;
      rx_perr_q    <= 1'b0;
      rx_overrun_q <= 1'b0;
    end else begin
      rx_s1_q      <= external_interface_RXD;
      rx_s2_q      <= rx_s1_q;
      rx_prev_q    <= rx_s2_q;
      rx_overrun_q <= rx_wr && rx_full && !rx_pop;
      if (rx_state_q == S_IDLE) begin
        if (rx_prev_q && !rx_s2_q) begin
          rx_state_q <= S_START;
          rx_baud_q  <= HALF_LAST;
        end
      end else if (!rx_tick) begin
        rx_baud_q <= rx_baud_q - 16'd1;
      end else begin
        rx_baud_q <= BAUD_LAST;
        case (rx_state_q)
          S_START: begin
            // Line back high at mid-start: treat it as a glitch.
            if (rx_s2_q) begin
              rx_state_q <= S_IDLE;
            end else begin
              rx_state_q <= S_DATA;
              rx_bit_q   <= '0;
              rx_stop_q  <= 1'b0;
              rx_perr_q  <= 1'b0;
            end
          end
          S_DATA: begin
            rx_shift_q <= {rx_s2_q, rx_shift_q[DATA_BITS-1:1]};
            if (rx_bit_q == BITS_LAST) rx_state_q <= HAS_PAR ? S_PARITY : S_STOP;
            else                       rx_bit_q   <= rx_bit_q + 4'd1;
          end
          S_PARITY: begin
            rx_perr_q  <= ((^rx_shift_q) ^ PAR_ODD) != rx_s2_q;
            rx_state_q <= S_STOP;
          end
          S_STOP: begin
            if (rx_stop_q == STOP_LAST) rx_state_q <= S_IDLE;
            else                        rx_stop_q  <= 1'b1;
          end
          default: rx_state_q <= S_IDLE;
        endcase
      end
    end
  end

`ifdef UART_HW_FLOWCTRL_EN
  localparam int RAW = $clog2(RX_DEPTH);

  logic           cts_s1_q;
  logic           cts_s2_q;
  logic           rts_q;
  logic [RAW:0]   rx_cnt_q;
  logic           rx_push_ok;

  assign rx_push_ok               = rx_wr && (!rx_full || rx_pop);
  assign cts_ok                   = !cts_s2_q;
  assign external_interface_RTS_N = rts_q;

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      cts_s1_q <= 1'b1;
      cts_s2_q <= 1'b1;
      rts_q    <= 1'b1;
      rx_cnt_q <= '0;
    end else begin
      cts_s1_q <= external_interface_CTS_N;
      cts_s2_q <= cts_s1_q;
      if (rx_push_ok && !rx_pop)      rx_cnt_q <= rx_cnt_q + 1'b1;
      else if (!rx_push_ok && rx_pop) rx_cnt_q <= rx_cnt_q - 1'b1;
      rts_q <= (rx_cnt_q >= (RAW+1)'(RX_DEPTH - 2));
    end
  end
`else
  assign cts_ok = 1'b1;
`endif
endmodule

// File: tb/tb_uart_st_fifo.sv
// tb/tb_uart_st_fifo.sv - scoreboard bench for uart_st_fifo (BAUD_DIV=4, 8E1, RX_DEPTH=4)
module tb_uart_st_fifo;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] sink_data = 8'h00;
  logic       sink_err = 1'b0;
  logic       sink_valid = 1'b0;
  logic       sink_ready;
  logic [7:0] src_data;
  logic [1:0] src_err;
  logic       src_valid;
  logic       src_ready = 1'b1;
  logic       overrun;
  logic       txd;
  logic       rxd;
  logic       rxd_drv = 1'b1;
  logic       loop_en = 1'b0;

  int         total = 0;
  int         bad = 0;
  int         ov_cnt = 0;
  bit         tx_mon_en = 1'b1;
  logic [9:0] rx_q[$];
  logic [7:0] tx_q[$];

  assign rxd = loop_en ? txd : rxd_drv;

  always #5 clk = ~clk;

  uart_st_fifo #(
    .BAUD_DIV(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .TX_DEPTH(16), .RX_DEPTH(4)
  ) dut (
    .clk_clk                          (clk),
    .reset_reset                      (rst),
    .avalon_data_transmit_sink_data   (sink_data),
    .avalon_data_transmit_sink_error  (sink_err),
    .avalon_data_transmit_sink_valid  (sink_valid),
    .avalon_data_transmit_sink_ready  (sink_ready),
    .avalon_data_receive_source_data  (src_data),
    .avalon_data_receive_source_error (src_err),
    .avalon_data_receive_source_valid (src_valid),
    .avalon_data_receive_source_ready (src_ready),
    .rx_overrun                       (overrun),
    .external_interface_RXD           (rxd),
    .external_interface_TXD           (txd)
  );

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] d, input logic e);
    int n;
    n = 0;
    sink_data  = d;
    sink_err   = e;
    sink_valid = 1'b1;
    @(negedge clk);
    while (!sink_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!sink_ready) begin
      total++;
      bad++;
      $display("FAIL push_timeout actual=ready_low required=ready_high");
    end
    @(posedge clk);
    #1;
    sink_valid = 1'b0;
  endtask

  task automatic drive_frame(input logic [7:0] d, input logic p, input logic stp);
    logic [10:0] f;
    f = {stp, p, d, 1'b0};
    for (int i = 0; i < 11; i++) begin
      rxd_drv = f[i];
      repeat (4) @(posedge clk);
      #1;
    end
    rxd_drv = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    logic [9:0] exp;
    if (overrun) ov_cnt++;
    if (!rst && src_valid && src_ready) begin
      if (rx_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rx_unexpected actual=%0h required=none", {src_err, src_data});
      end else begin
        exp = rx_q.pop_front();
        check("rx_word", {src_err, src_data}, exp);
      end
    end
  end

  initial begin : tx_mon
    logic        prev;
    logic [10:0] fr;
    logic [7:0]  exp;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (tx_mon_en && !rst && prev && !txd) begin
        @(negedge clk);
        fr[0] = txd;
        for (int i = 1; i < 11; i++) begin
          repeat (4) @(negedge clk);
          fr[i] = txd;
        end
        if (tx_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL tx_unexpected actual=%0h required=none", fr[8:1]);
        end else begin
          exp = tx_q.pop_front();
          check("tx_data", fr[8:1], exp);
          check("tx_format", {fr[0], fr[9], fr[10]}, {1'b0, ^exp, 1'b1});
        end
      end
      prev = txd;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    int          errs;
    logic [10:0] w;

    @(posedge clk);
    #1;
    check("rst_txd", txd, 1);
    check("rst_sink_ready", sink_ready, 0);
    check("rst_src_valid", src_valid, 0);
    check("rst_src_data", src_data, 0);
    check("rst_src_err", src_err, 0);
    check("rst_overrun", overrun, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_sink_ready", sink_ready, 1);
    @(posedge clk);
    #1;

    // 0xA5, even parity bit 0: waveform and start latency
    tx_q.push_back(8'hA5);
    push(8'hA5, 1'b0);
    lat = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (!txd) break;
      lat++;
    end
    total++;
    if (lat > 2) begin
      bad++;
      $display("FAIL tx_latency actual=%0d required<=2", lat);
    end
    w = {1'b1, 1'b0, 8'hA5, 1'b0};
    errs = 0;
    for (int s = 0; s < 44; s++) begin
      if (s > 0) @(negedge clk);
      if (txd != w[s/4]) errs++;
    end
    check("a5_wave", errs, 0);
    repeat (10) @(posedge clk);
    #1;

    // loopback of 16 back-to-back words
    loop_en = 1'b1;
    for (int d = 0; d < 16; d++) begin
      tx_q.push_back(8'(d));
      rx_q.push_back({2'b00, 8'(d)});
      push(8'(d), 1'b0);
    end
    repeat (16 * 44 + 60) @(posedge clk);
    #1;
    check("lb_rx_drained", rx_q.size(), 0);
    check("lb_tx_drained", tx_q.size(), 0);
    loop_en = 1'b0;
    repeat (10) @(posedge clk);
    #1;

    // parity error then framing error, data 0x3C
    rx_q.push_back({2'b10, 8'h3C});
    drive_frame(8'h3C, 1'b1, 1'b1);
    rx_q.push_back({2'b01, 8'h3C});
    drive_frame(8'h3C, 1'b0, 1'b0);
    repeat (20) @(posedge clk);
    #1;
    check("err_rx_drained", rx_q.size(), 0);
    check("no_overrun_yet", ov_cnt, 0);

    // overrun on the fifth frame with source stalled
    src_ready = 1'b0;
    ov_cnt    = 0;
    rx_q.push_back({2'b00, 8'h11});
    rx_q.push_back({2'b00, 8'h22});
    rx_q.push_back({2'b00, 8'h33});
    rx_q.push_back({2'b00, 8'h44});
    drive_frame(8'h11, ^8'h11, 1'b1);
    drive_frame(8'h22, ^8'h22, 1'b1);
    drive_frame(8'h33, ^8'h33, 1'b1);
    drive_frame(8'h44, ^8'h44, 1'b1);
    drive_frame(8'h55, ^8'h55, 1'b1);
    repeat (10) @(posedge clk);
    #1;
    check("ovr_src_valid", src_valid, 1);
    check("ovr_pulses", ov_cnt, 1);
    check("ovr_head", src_data, 8'h11);
    src_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("ovr_drained", rx_q.size(), 0);

    // error-flagged word dropped, 0x55 sent
    tx_q.push_back(8'h55);
    push(8'hFF, 1'b1);
    push(8'h55, 1'b0);
    repeat (60) @(posedge clk);
    #1;
    check("err_drop_tx", tx_q.size(), 0);

    // one-cycle glitch on RXD
    rxd_drv = 1'b0;
    @(posedge clk);
    #1;
    rxd_drv = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check("glitch_none", src_valid, 0);

    // reset in the middle of a TX frame
    tx_mon_en = 1'b0;
    push(8'h00, 1'b0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (!txd) break;
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_txd", txd, 1);
    check("midrst_sink_ready", sink_ready, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rel_sink_ready", sink_ready, 1);
    check("rel_src_valid", src_valid, 0);
    errs = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (!txd) errs++;
    end
    check("rel_txd_idle", errs, 0);
    tx_mon_en = 1'b1;
    @(posedge clk);
    #1;
    tx_q.push_back(8'h3C);
    push(8'h3C, 1'b0);
    repeat (60) @(posedge clk);
    #1;
    check("rel_tx_drained", tx_q.size(), 0);
    check("final_rx_drained", rx_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
